// File: rtl/analyzer_scan_ctrl.sv
// analyzer_scan_ctrl: steps one-hot drive across matrix lines, settles, samples ch_in, reports per-line results
module analyzer_scan_ctrl #(
    parameter int NUM_CH        = 5,
    parameter int SETTLE_CYCLES = 4,
    parameter int SAMPLE_COUNT  = 16,
    localparam int CNT_W        = $clog2(SAMPLE_COUNT + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [NUM_CH-1:0] ch_in,
    output logic [NUM_CH-1:0] drive_en,
    output logic              busy,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [2:0]        res_ch,
    output logic [CNT_W-1:0]  res_count,
    output logic              res_xtalk,
    output logic              res_pass,
    output logic              done,
    output logic              aborted
);
    localparam int TMAX = (SETTLE_CYCLES > SAMPLE_COUNT) ? SETTLE_CYCLES : SAMPLE_COUNT;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, REPORT} state_t;

    state_t            state, state_nx;
    logic [2:0]        cur;
    logic [TW-1:0]     tmr;
    logic [CNT_W-1:0]  acc, cnt_nx;
    logic              xt, xt_nx;
    logic [NUM_CH-1:0] sel;
    logic              accept, last_ch;

    always_ff @(posedge clk)
        state <= !rst_n ? IDLE : state_nx;

    always_comb begin
        sel      = NUM_CH'(1) << cur;
        cnt_nx   = acc + CNT_W'(|(ch_in & sel));
        xt_nx    = xt | (|(ch_in & ~sel));
        accept   = state == REPORT && res_ready;
        last_ch  = cur == 3'(NUM_CH - 1);
        state_nx = state;
        // abort outranks every other transition once a scan is running
        if (state != IDLE && abort)
            state_nx = IDLE;
        else
            case (state)
                IDLE:    state_nx = start ? SETTLE : IDLE;
                SETTLE:  state_nx = tmr == TW'(SETTLE_CYCLES - 1) ? SAMPLE : SETTLE;
                SAMPLE:  state_nx = tmr == TW'(SAMPLE_COUNT - 1) ? REPORT : SAMPLE;
                default: state_nx = res_ready ? (last_ch ? IDLE : SETTLE) : REPORT;
            endcase
        drive_en  = (state == SETTLE || state == SAMPLE) ? sel : '0;
        busy      = state != IDLE;
        res_valid = state == REPORT;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur       <= '0;
            tmr       <= '0;
            acc       <= '0;
            xt        <= 1'b0;
            res_ch    <= '0;
            res_count <= '0;
            res_xtalk <= 1'b0;
            res_pass  <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            done    <= accept && last_ch && !abort;
            aborted <= abort && state != IDLE;
            tmr     <= (state_nx == state) ? tmr + TW'(1) : '0;
            cur     <= (state_nx == IDLE) ? 3'd0 : (accept && state_nx == SETTLE) ? cur + 3'd1 : cur;
            acc     <= (state == SAMPLE) ? cnt_nx : '0;
            xt      <= (state == SAMPLE) ? xt_nx : 1'b0;
            // result fields only move on REPORT entry, so they hold through backpressure
            if (state == SAMPLE && state_nx == REPORT) begin
                res_ch    <= cur;
                res_count <= cnt_nx;
                res_xtalk <= xt_nx;
                res_pass  <= cnt_nx == CNT_W'(SAMPLE_COUNT) && !xt_nx;
            end
        end
    end
endmodule

// File: tb/tb_analyzer_scan_ctrl.sv
// tb_analyzer_scan_ctrl: directed loopback scenarios plus randomized sample patterns against a line-result model
module tb_analyzer_scan_ctrl;
    localparam int NC = 5, S = 4, N = 16, CW = $clog2(N + 1);
    localparam int LINE_T = S + N + 1;

    logic clk = 0, rst_n = 0, start = 0, abort = 0, res_ready = 0, lb_en = 1;
    logic [NC-1:0] ch_in, drive_en;
    logic [NC-1:0] lb_q = '0, rnd_ch = '0, stuck = '0, xsrc = '0, xdst = '0;
    logic busy, res_valid, res_xtalk, res_pass, done, aborted;
    logic [2:0] res_ch;
    logic [CW-1:0] res_count;
    int checks = 0, errors = 0;

    analyzer_scan_ctrl #(.NUM_CH(NC), .SETTLE_CYCLES(S), .SAMPLE_COUNT(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .ch_in(ch_in),
        .drive_en(drive_en), .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
        .res_ch(res_ch), .res_count(res_count), .res_xtalk(res_xtalk), .res_pass(res_pass),
        .done(done), .aborted(aborted)
    );

    always #5 clk = ~clk;

    // analyzer register stage: drive looped back one cycle late, with optional faults
    always @(posedge clk)
        lb_q <= (drive_en & ~stuck) | ((|(drive_en & xsrc)) ? xdst : '0);

    assign ch_in = lb_en ? lb_q : rnd_ch;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void exp_line(input int l, output int cnt, output bit xt);
        logic [NC-1:0] oh, v;
        oh  = NC'(1) << l;
        v   = (oh & ~stuck) | ((|(oh & xsrc)) ? xdst : '0);
        cnt = (l < NC && v[l]) ? N : 0;
        xt  = |(v & ~oh);
    endfunction

    task automatic wait_drv(input string tag, input logic [NC-1:0] v);
        int i = 0;
        while (drive_en !== v && i < 300) begin tick(); i++; end
        chk(tag, drive_en, v);
    endtask

    task automatic wait_valid(input string tag);
        int i = 0;
        while (!res_valid && i < 100) begin tick(); i++; end
        chk(tag, res_valid, 1);
    endtask

    task automatic run_scan(input string nm);
        int line = 0, busy_n = 0, done_rel = -1, fv = -1, ec;
        bit ex;
        res_ready = 1;
        start = 1;
        tick();
        start = 0;
        for (int rel = 0; rel < 140; rel++) begin
            if (busy) busy_n++;
            if (res_valid) begin
                if (fv < 0) fv = rel;
                exp_line(line, ec, ex);
                chk({nm, "_ch"}, res_ch, line);
                chk({nm, "_cnt"}, res_count, ec);
                chk({nm, "_xt"}, res_xtalk, ex);
                chk({nm, "_pass"}, res_pass, ec == N && !ex);
                line++;
            end
            if (done) done_rel = rel;
            if (aborted) chk({nm, "_abort"}, aborted, 0);
            tick();
        end
        chk({nm, "_lines"}, line, NC);
        chk({nm, "_busy_len"}, busy_n, NC * LINE_T);
        chk({nm, "_done_at"}, done_rel, NC * LINE_T);
        chk({nm, "_first_valid"}, fv, S + N);
        res_ready = 0;
    endtask

    task automatic rand_scan();
        logic [NC-1:0] pat [NC][N];
        logic [NC-1:0] oh, v;
        int cnt [NC];
        bit xt [NC];
        int mode;
        for (int l = 0; l < NC; l++) begin
            oh = NC'(1) << l;
            mode = $urandom_range(0, 3);
            cnt[l] = 0;
            xt[l] = 0;
            for (int j = 0; j < N; j++) begin
                v = oh;
                if (mode == 1 && $urandom_range(0, 3) == 0) v = '0;
                if (mode == 2 && $urandom_range(0, 7) == 0) v = v | NC'($urandom);
                if (mode == 3) v = NC'($urandom);
                pat[l][j] = v;
                cnt[l] += v[l] ? 1 : 0;
                xt[l] = xt[l] | (|(v & ~oh));
            end
        end
        res_ready = 0;
        start = 1;
        tick();
        start = 0;
        for (int l = 0; l < NC; l++) begin
            oh = NC'(1) << l;
            for (int i = 0; i < S; i++) begin
                chk("rnd_settle_drv", drive_en, oh);
                rnd_ch = NC'($urandom);
                tick();
            end
            for (int j = 0; j < N; j++) begin
                chk("rnd_sample_drv", drive_en, oh);
                rnd_ch = pat[l][j];
                tick();
            end
            for (int w = $urandom_range(0, 3); w >= 0; w--) begin
                rnd_ch = NC'($urandom);
                chk("rnd_result", {res_valid, res_ch, res_count, res_xtalk, res_pass, drive_en},
                    {1'b1, 3'(l), CW'(cnt[l]), xt[l], cnt[l] == N && !xt[l], NC'(0)});
                if (w == 0) res_ready = 1;
                tick();
            end
            res_ready = 0;
        end
        chk("rnd_done", {done, busy}, 2'b10);
        tick();
        chk("rnd_done_pulse", done, 0);
    endtask

    initial begin
        int rel;
        rst_n = 0;
        tick();
        tick();
        chk("rst_drive_en", drive_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", res_valid, 0);
        chk("rst_fields", {res_ch, res_count, res_xtalk, res_pass}, 0);
        chk("rst_pulses", {done, aborted}, 0);
        rst_n = 1;
        tick();

        abort = 1;
        tick();
        abort = 0;
        chk("idle_abort", {aborted, busy}, 0);

        run_scan("loop");
        stuck = 5'b00100;
        run_scan("stuck");
        stuck = '0;
        xsrc = 5'b00010;
        xdst = 5'b01000;
        run_scan("xtalk");
        xsrc = '0;
        xdst = '0;

        // backpressure on line 0
        res_ready = 0;
        start = 1;
        tick();
        start = 0;
        wait_valid("bp_valid");
        for (int i = 0; i < 10; i++) begin
            chk("bp_hold", {res_valid, res_ch, res_count, res_xtalk, res_pass, drive_en},
                {1'b1, 3'd0, CW'(N), 1'b0, 1'b1, NC'(0)});
            tick();
        end
        res_ready = 1;
        tick();
        res_ready = 0;
        chk("bp_accept", {res_valid, drive_en, busy}, {1'b0, NC'(2), 1'b1});
        abort = 1;
        tick();
        abort = 0;
        chk("bp_abort", {aborted, busy, done, drive_en}, {1'b1, 1'b0, 1'b0, NC'(0)});
        tick();
        chk("bp_abort_pulse", aborted, 0);

        // abort during line 3 sampling, then a fresh scan
        res_ready = 1;
        start = 1;
        tick();
        start = 0;
        wait_drv("ab_reach3", 5'b01000);
        repeat (S + 2) tick();
        chk("ab_in_sample", {res_valid, drive_en}, {1'b0, NC'(8)});
        abort = 1;
        tick();
        abort = 0;
        chk("ab_idle", {busy, drive_en, res_valid, aborted, done}, {1'b0, NC'(0), 1'b0, 1'b1, 1'b0});
        tick();
        chk("ab_pulse", {aborted, done}, 0);
        run_scan("restart");

        // second start while busy is ignored, then reset mid-SETTLE
        res_ready = 1;
        start = 1;
        tick();
        start = 0;
        tick();
        start = 1;
        tick();
        start = 0;
        rel = 2;
        while (!res_valid && rel < 60) begin tick(); rel++; end
        chk("dbl_start_rel", rel, S + N);
        wait_drv("rst_reach1", 5'b00010);
        tick();
        rst_n = 0;
        tick();
        rst_n = 1;
        chk("midrst_out", {drive_en, busy, res_valid, res_ch, res_count, res_xtalk, res_pass, done, aborted}, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("midrst_idle", {busy, drive_en, done, aborted}, 0);
        end

        // start beats abort in IDLE; abort beats last acceptance
        abort = 1;
        start = 1;
        tick();
        abort = 0;
        start = 0;
        chk("start_abort_idle", {busy, aborted}, 2'b10);
        abort = 1;
        tick();
        abort = 0;
        chk("abort_settle", {aborted, busy}, 2'b10);
        res_ready = 1;
        start = 1;
        tick();
        start = 0;
        wait_drv("last_reach4", 5'b10000);
        res_ready = 0;
        wait_valid("last_valid");
        chk("last_ch", res_ch, 4);
        res_ready = 1;
        abort = 1;
        tick();
        res_ready = 0;
        abort = 0;
        chk("last_abort", {aborted, done, busy, res_valid}, 4'b1000);
        tick();
        chk("last_abort_pulse", {aborted, done}, 0);

        lb_en = 0;
        repeat (6) rand_scan();
        lb_en = 1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
